// File: rtl/exposure_sequencer_if.sv
// exposure_sequencer_if: host command, table write and pulse-timer signal bundle for exposure_sequencer
interface exposure_sequencer_if;
  logic       iWR_EN;
  logic [3:0] iWR_ADDR;
  logic [7:0] iWR_DATA;
  logic [4:0] iNUM_FRAMES;
  logic [7:0] iLOOP_COUNT;
  logic       iSTART;
  logic       iABORT;
  logic       iPULSE;
  logic       oTRIGGER;
  logic [7:0] oMILLISEC_TO_COUNT;
  logic [3:0] oFRAME_INDEX;
  logic       oBUSY;
  logic       oDONE;
  modport master (
    output iWR_EN, iWR_ADDR, iWR_DATA, iNUM_FRAMES, iLOOP_COUNT, iSTART, iABORT, iPULSE,
    input  oTRIGGER, oMILLISEC_TO_COUNT, oFRAME_INDEX, oBUSY, oDONE
  );
  modport slave (
    input  iWR_EN, iWR_ADDR, iWR_DATA, iNUM_FRAMES, iLOOP_COUNT, iSTART, iABORT, iPULSE,
    output oTRIGGER, oMILLISEC_TO_COUNT, oFRAME_INDEX, oBUSY, oDONE
  );
endinterface

// File: rtl/exposure_sequencer.sv
// exposure_sequencer: walks a 16-entry exposure table, triggering the ms pulse timer once per frame
module exposure_sequencer #(
  parameter int TRIG_CYCLES = 2,
  parameter int GAP_CYCLES  = 4
) (
  input logic iCLOCK50,
  input logic iRST_N,
  exposure_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_HIGH = 3'd2;
  localparam logic [2:0] WAIT_LOW  = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam logic [2:0] ADVANCE   = 3'd5;
  localparam int TW = TRIG_CYCLES > 1 ? $clog2(TRIG_CYCLES) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  logic [2:0]    state, stateNext;
  logic [3:0]    frame, frameNext;
  logic [7:0]    entry [16];
  logic [4:0]    numFrames;
  logic [7:0]    loopCount, passCnt, msCount;
  logic [TW-1:0] trigCnt;
  logic [GW-1:0] gapCnt;
  logic          pulseSeen, startOk, lastFrame, passDone, trigLast, gapLast, abort;
  assign startOk   = bus.iSTART && bus.iNUM_FRAMES != 5'd0 && bus.iNUM_FRAMES <= 5'd16;
  assign lastFrame = {1'b0, frame} == numFrames - 5'd1;
  assign passDone  = loopCount != 8'd0 && passCnt + 8'd1 >= loopCount;
  assign trigLast  = int'(trigCnt) == TRIG_CYCLES - 1;
  assign gapLast   = GAP_CYCLES <= 1 || int'(gapCnt) == GAP_CYCLES - 1;
  assign abort     = state != IDLE && bus.iABORT;
  assign bus.oTRIGGER           = state == TRIG && !bus.iABORT;
  assign bus.oMILLISEC_TO_COUNT = msCount;
  assign bus.oFRAME_INDEX       = frame;
  assign bus.oBUSY              = state != IDLE;
  assign bus.oDONE              = state == ADVANCE && lastFrame && passDone && !bus.iABORT;
  always_comb begin
    stateNext = state;
    frameNext = frame;
    case (state)
      IDLE:      stateNext = startOk ? TRIG : IDLE;
      TRIG:      stateNext = trigLast ? WAIT_HIGH : TRIG;
      WAIT_HIGH: stateNext = (pulseSeen || bus.iPULSE) ? WAIT_LOW : WAIT_HIGH;
      WAIT_LOW:  stateNext = bus.iPULSE ? WAIT_LOW : GAP;
      GAP:       stateNext = gapLast ? ADVANCE : GAP;
      ADVANCE:   stateNext = (!lastFrame || !passDone) ? TRIG : IDLE;
      default:   stateNext = IDLE;
    endcase
    if (state == IDLE && startOk) frameNext = 4'd0;
    if (state == ADVANCE) frameNext = lastFrame ? 4'd0 : frame + 4'd1;
    if (abort) begin
      stateNext = IDLE;
      frameNext = 4'd0;
    end
  end
  always_ff @(posedge iCLOCK50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      frame     <= 4'd0;
      numFrames <= 5'd0;
      loopCount <= 8'd0;
      passCnt   <= 8'd0;
      msCount   <= 8'd0;
      trigCnt   <= '0;
      gapCnt    <= '0;
      pulseSeen <= 1'b0;
      for (int i = 0; i < 16; i++) entry[i] <= 8'd0;
    end else begin
      state     <= stateNext;
      frame     <= frameNext;
      trigCnt   <= (state == TRIG && !trigLast) ? trigCnt + TW'(1) : '0;
      gapCnt    <= (state == GAP && !gapLast) ? gapCnt + GW'(1) : '0;
      // a pulse that rises and falls inside TRIG is remembered for WAIT_HIGH
      pulseSeen <= state == TRIG ? (pulseSeen || bus.iPULSE) : (state == WAIT_HIGH && pulseSeen);
      if (state == IDLE && startOk) begin
        numFrames <= bus.iNUM_FRAMES;
        loopCount <= bus.iLOOP_COUNT;
        passCnt   <= 8'd0;
      end else if (state == ADVANCE && lastFrame && loopCount != 8'd0) begin
        passCnt <= passCnt + 8'd1;
      end
      if (abort) passCnt <= 8'd0;
      if (bus.iWR_EN && state == IDLE) entry[bus.iWR_ADDR] <= bus.iWR_DATA;
      if (stateNext == TRIG && state != TRIG) msCount <= entry[frameNext];
    end
  end
endmodule

// File: tb/tb_exposure_sequencer.sv
// tb_exposure_sequencer: randomized scoreboard bench with a behavioural pulse-timer and table model
module tb_exposure_sequencer;
  localparam int TRIG_CYCLES = 2;
  localparam int GAP_CYCLES  = 4;
  typedef struct { bit isDone; int frame; int ms; } ev_t;
  logic clk  = 1'b0;
  logic rstN = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   refTab [16];
  int   bad [3] = '{0, 17, 31};
  bit   timerOn = 1'b1;
  ev_t  expQ [$];
  ev_t  cur, ev;
  bit   haveCur = 1'b0;
  exposure_sequencer_if sif ();
  exposure_sequencer #(.TRIG_CYCLES(TRIG_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut (
    .iCLOCK50(clk),
    .iRST_N  (rstN),
    .bus     (sif)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected event stream of a finite run, taken straight from the table contents
  task automatic pushRun(input int n, input int loops);
    for (int p = 0; p < loops; p++)
      for (int f = 0; f < n; f++) expQ.push_back('{1'b0, f, refTab[f]});
    expQ.push_back('{1'b1, 0, 0});
  endtask

  task automatic writeEntry(input int addr, input int data, input bit idle);
    sif.iWR_EN   = 1'b1;
    sif.iWR_ADDR = 4'(addr);
    sif.iWR_DATA = 8'(data);
    @(negedge clk);
    sif.iWR_EN = 1'b0;
    if (idle) refTab[addr] = data;
  endtask

  task automatic startRun(input int n, input int loops);
    int k = 0;
    sif.iNUM_FRAMES = 5'(n);
    sif.iLOOP_COUNT = 8'(loops);
    sif.iSTART      = 1'b1;
    do begin @(negedge clk); k++; end while (!sif.oBUSY && k < 10);
    check("start_busy", sif.oBUSY, 1);
    sif.iSTART = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end while (sif.oBUSY && k < budget);
    check("run_end_idle", sif.oBUSY, 0);
    check("events_drained", expQ.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // pulse timer model: pulse rises after trigger, lasts ms+3 clocks (0 ms: one clock inside TRIG)
  initial begin
    int  left;
    bit  trigPrev;
    left = 0;
    trigPrev = 1'b0;
    sif.iPULSE = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstN) begin
        left = 0;
        sif.iPULSE = 1'b0;
      end else if (left > 0) begin
        left--;
        if (left == 0) sif.iPULSE = 1'b0;
      end else if (timerOn && sif.oTRIGGER && !trigPrev) begin
        sif.iPULSE = 1'b1;
        left = sif.oMILLISEC_TO_COUNT == 8'd0 ? 1 : int'(sif.oMILLISEC_TO_COUNT) + 3;
      end
      trigPrev = sif.oTRIGGER;
    end
  end

  // monitor: pops the scoreboard on each trigger rise and each oDONE
  initial begin
    int hi, fallCyc;
    bit pPrev, trPrev, gapArmed;
    hi = 0; fallCyc = 0; pPrev = 0; trPrev = 0; gapArmed = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstN) begin
        hi = 0; pPrev = 0; trPrev = 0; gapArmed = 0; haveCur = 0;
        continue;
      end
      if (sif.oTRIGGER && !trPrev) begin
        if (gapArmed) check("gap_len", cyc - fallCyc, GAP_CYCLES + 2);
        gapArmed = 0;
        check("trigger_expected", int'(expQ.size() > 0 && !expQ[0].isDone), 1);
        if (expQ.size() > 0) begin
          ev = expQ.pop_front();
          if (!ev.isDone) begin
            cur = ev;
            haveCur = 1;
          end
          check("frame_index", int'(sif.oFRAME_INDEX), ev.frame);
          check("ms_value", int'(sif.oMILLISEC_TO_COUNT), ev.ms);
        end
      end
      if (sif.oTRIGGER) hi++;
      else if (trPrev) begin
        check("trig_width", hi, TRIG_CYCLES);
        hi = 0;
      end
      if (sif.oBUSY && haveCur) check("ms_hold", int'(sif.oMILLISEC_TO_COUNT), cur.ms);
      if (!sif.iPULSE && pPrev && !sif.oTRIGGER) begin
        gapArmed = 1;
        fallCyc = cyc;
      end
      if (!sif.oBUSY) gapArmed = 0;
      if (sif.oDONE) begin
        check("done_expected", int'(expQ.size() > 0 && expQ[0].isDone), 1);
        if (expQ.size() > 0) void'(expQ.pop_front());
      end
      pPrev = sif.iPULSE;
      trPrev = sif.oTRIGGER;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int k, n, l;
    for (int i = 0; i < 16; i++) refTab[i] = 0;
    sif.iWR_EN = 0; sif.iWR_ADDR = 0; sif.iWR_DATA = 0;
    sif.iNUM_FRAMES = 0; sif.iLOOP_COUNT = 0; sif.iSTART = 0; sif.iABORT = 0;
    #2 rstN = 1'b0;
    #1;
    check("rst_trigger", sif.oTRIGGER, 0);
    check("rst_ms", int'(sif.oMILLISEC_TO_COUNT), 0);
    check("rst_frame", int'(sif.oFRAME_INDEX), 0);
    check("rst_busy", sif.oBUSY, 0);
    check("rst_done", sif.oDONE, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    // three frames 3,1,0 ms, single pass
    writeEntry(0, 3, 1); writeEntry(1, 1, 1); writeEntry(2, 0, 1);
    pushRun(3, 1); startRun(3, 1); waitIdle(5000);
    // two passes over two frames
    writeEntry(0, $urandom_range(1, 20), 1); writeEntry(1, $urandom_range(0, 20), 1);
    pushRun(2, 2); startRun(2, 2); waitIdle(5000);
    // infinite looping, aborted inside WAIT_LOW of the third frame
    writeEntry(0, 1, 1);
    for (int i = 0; i < 3; i++) expQ.push_back('{1'b0, 0, 1});
    startRun(1, 0);
    k = 0;
    while (expQ.size() > 0 && k < 2000) begin @(negedge clk); k++; end
    check("infinite_triggers", expQ.size(), 0);
    k = 0;
    while (!(sif.iPULSE && !sif.oTRIGGER) && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    check("busy_before_abort", sif.oBUSY, 1);
    sif.iABORT = 1'b1;
    @(negedge clk);
    sif.iABORT = 1'b0;
    check("abort_idle", sif.oBUSY, 0);
    check("abort_no_done", sif.oDONE, 0);
    repeat (300) @(negedge clk);
    check("abort_still_idle", sif.oBUSY, 0);
    // write while busy is dropped; frame 5 keeps its earlier value
    for (int i = 0; i < 6; i++) writeEntry(i, $urandom_range(0, 255), 1);
    pushRun(6, 1); startRun(6, 1);
    writeEntry(5, (refTab[5] + 100) % 256, 0);
    waitIdle(10000);
    pushRun(6, 1); startRun(6, 1); waitIdle(10000);
    // out-of-range frame counts never leave IDLE
    for (int i = 0; i < 3; i++) begin
      sif.iNUM_FRAMES = 5'(bad[i]); sif.iLOOP_COUNT = 8'd1; sif.iSTART = 1'b1;
      repeat (5) @(negedge clk);
      check("bad_start_idle", sif.oBUSY, 0);
      sif.iSTART = 1'b0;
    end
    // start held through completion restarts right after the IDLE cycle
    writeEntry(0, $urandom_range(0, 10), 1);
    pushRun(1, 1); pushRun(1, 1);
    sif.iNUM_FRAMES = 5'd1; sif.iLOOP_COUNT = 8'd1; sif.iSTART = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!sif.oDONE && k < 2000);
    check("done_seen", sif.oDONE, 1);
    @(negedge clk);
    check("idle_after_done", sif.oBUSY, 0);
    @(negedge clk);
    check("restart_busy", sif.oBUSY, 1);
    sif.iSTART = 1'b0;
    waitIdle(2000);
    // timer disconnected: hold in WAIT_HIGH until aborted
    timerOn = 1'b0;
    expQ.push_back('{1'b0, 0, refTab[0]});
    startRun(1, 1);
    repeat (200) @(negedge clk);
    check("stuck_busy", sif.oBUSY, 1);
    check("stuck_trigger", sif.oTRIGGER, 0);
    sif.iABORT = 1'b1;
    @(negedge clk);
    sif.iABORT = 1'b0;
    check("stuck_abort_idle", sif.oBUSY, 0);
    check("stuck_events", expQ.size(), 0);
    timerOn = 1'b1;
    repeat (2) @(negedge clk);
    // randomized runs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) writeEntry($urandom_range(0, 15), $urandom_range(0, 255), 1);
      n = $urandom_range(1, 6);
      l = $urandom_range(1, 3);
      pushRun(n, l); startRun(n, l); waitIdle(20000);
    end
    // asynchronous reset during TRIG clears outputs and the table
    for (int i = 0; i < 3; i++) writeEntry(i, $urandom_range(1, 255), 1);
    pushRun(3, 1); startRun(3, 1);
    check("trig_before_reset", sif.oTRIGGER, 1);
    #2 rstN = 1'b0;
    #1;
    check("midrst_trigger", sif.oTRIGGER, 0);
    check("midrst_busy", sif.oBUSY, 0);
    check("midrst_ms", int'(sif.oMILLISEC_TO_COUNT), 0);
    check("midrst_frame", int'(sif.oFRAME_INDEX), 0);
    check("midrst_done", sif.oDONE, 0);
    expQ.delete();
    for (int i = 0; i < 16; i++) refTab[i] = 0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    pushRun(3, 1); startRun(3, 1); waitIdle(5000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exposure_sequencer.md
Name: exposure_sequencer

Overview:
- Upstream driver for the millisecond pulse timer; steps through a 16-entry table of per-frame exposure durations (ms).
- Per frame: presents the duration, issues a trigger, waits for the timer's pulse to complete, inserts a gap, then advances. Supports finite or infinite looping over the table.
- Sits between the host/command register block and the pulse timer in the SLM display timing path.

Parameters:
- TRIG_CYCLES, 2, trigger high length in clocks (>=1)
- GAP_CYCLES, 4, idle clocks between pulse fall and next trigger (>=0)

Ports:
- iCLOCK50  in  1  system clock, 50 MHz
- iRST_N  in  1  asynchronous active-low reset
- iWR_EN  in  1  table write strobe; ignored while oBUSY=1
- iWR_ADDR  in  4  table entry address
- iWR_DATA  in  8  duration in ms for that entry
- iNUM_FRAMES  in  5  table entries to use (1..16), latched at start
- iLOOP_COUNT  in  8  passes over table, latched at start; 0 = infinite
- iSTART  in  1  level; acted on only in IDLE
- iABORT  in  1  synchronous abort, priority over all but reset
- iPULSE  in  1  pulse output of the ms timer
- oTRIGGER  out  1  trigger to the ms timer
- oMILLISEC_TO_COUNT  out  8  duration to the ms timer
- oFRAME_INDEX  out  4  current table entry
- oBUSY  out  1  high in every state except IDLE
- oDONE  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (iRST_N=0, async): state IDLE; all outputs 0; table cleared to 0; latched counts cleared.
- Table write: when iWR_EN=1 and oBUSY=0, entry[iWR_ADDR] <= iWR_DATA at the clock edge. Writes while busy are dropped.
- IDLE: if iSTART=1 and iNUM_FRAMES in 1..16, latch iNUM_FRAMES/iLOOP_COUNT, frame=0, pass=0, go to TRIG. iNUM_FRAMES=0 or >16: start ignored, remain IDLE.
- TRIG: oTRIGGER=1 for exactly TRIG_CYCLES clocks. oMILLISEC_TO_COUNT = entry[frame], registered and valid from the first TRIG cycle. Then go to WAIT_HIGH.
- oMILLISEC_TO_COUNT: held stable from TRIG entry until the next TRIG.
- WAIT_HIGH:
  - If iPULSE was seen high during TRIG or is now high, go to WAIT_LOW.
  - Otherwise wait indefinitely; iABORT is the escape.
- WAIT_LOW: wait until iPULSE=0, then go to GAP. A 0 ms entry is legal: the pulse is high only around the trigger, so this state may last 1 cycle.
- GAP: count GAP_CYCLES clocks (0 means pass straight through in 1 cycle), then ADVANCE.
- ADVANCE (1 cycle):
  - If frame < NUM_FRAMES-1: frame++ and go to TRIG.
  - Else frame=0 and pass++. If loop count is 0 (infinite) or pass < loop count, go to TRIG; otherwise go to IDLE with oDONE=1 for that cycle.
- Pass counter: 8-bit; does not advance in infinite mode.
- oFRAME_INDEX = frame register; updates at ADVANCE.
- Abort: iABORT=1 in any non-IDLE state forces oTRIGGER=0 and state IDLE next cycle. Frame and pass are cleared; oDONE stays 0. iABORT in IDLE has no effect.
- iSTART held high after completion restarts immediately. The cycle after oDONE is IDLE; the start is accepted there.
- Reset mid-sequence: immediate return to IDLE, table cleared, oTRIGGER drops asynchronously.

Test Plan:
- Reset then write entries 0..2 = 3,1,0; NUM_FRAMES=3, LOOP=1, start; timer modelled -> three triggers of 2 cycles, each with oMILLISEC_TO_COUNT 3,1,0 respectively. Gaps of 4 clocks after each pulse fall. Single oDONE; oBUSY low afterwards.
- LOOP=2, NUM_FRAMES=2 -> oFRAME_INDEX sequence 0,1,0,1 then oDONE; 4 triggers total.
- LOOP=0 (infinite), NUM_FRAMES=1, entry0=1 -> triggers ~every 50000+gap clocks indefinitely. iABORT mid-WAIT_LOW -> oBUSY=0 next cycle, no oDONE, no further triggers.
- Write to addr 5 while busy -> entry 5 unchanged after run (read back via a run with NUM_FRAMES=6). iNUM_FRAMES=0 with iSTART=1 -> stays IDLE.
- iRST_N asserted during TRIG -> oTRIGGER=0 immediately, all outputs 0. After release, a run of any entry yields oMILLISEC_TO_COUNT=0.
- iPULSE stuck low (timer disconnected) -> sequencer holds WAIT_HIGH with oBUSY=1; iABORT recovers to IDLE.
